// File: rtl/uart_pkg.sv
// Shared UART definitions (receiver and transmitter): FSM states, frame layout, counter sizing.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } uart_state_e;

  localparam int DATA_BITS   = 8;
  localparam int START_IDX   = 0;
  localparam int STOP_IDX    = 9;
  localparam int CPB_DEFAULT = 1085;  // 125 MHz / 115200 baud
  localparam int CNT_W       = 11;

  // 2-of-3 majority vote, used to reject single-clock line glitches
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Receiver-side bundle: serial line in, recovered byte / status pulses / progress counters out.
// Latency: n/a (wiring only).
// Backpressure: none; o_valid and o_frame_err are single-cycle pulses the consumer must take.
interface uart_rx_8n1_if;
  import uart_pkg::*;

  logic                 i_Rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_busy;
  logic [3:0]           o_bit_count;
  logic [CNT_W-1:0]     o_CPB_count;

  // master drives the line and observes the receiver
  modport master (
    output i_Rx,
    input  o_data, o_valid, o_frame_err, o_busy, o_bit_count, o_CPB_count
  );

  // slave is the receiver itself
  modport slave (
    input  i_Rx,
    output o_data, o_valid, o_frame_err, o_busy, o_bit_count, o_CPB_count
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the async rx pin plus falling-edge detect and neighbour taps.
// Latency: SYNC_FF clocks from pin to rx_s_o; fall_o is valid in the cycle rx_s_o first reads low.
// Backpressure: none.
module uart_rx_sync #(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,      // synchronized line
  output logic rx_ahead_o,  // value rx_s_o will take next cycle
  output logic rx_prev_o,   // value rx_s_o had last cycle
  output logic fall_o
);

  logic [SYNC_FF-1:0] sync_q;
  logic               prev_q;

  // shift the pin through the chain; idle-high reset so no false start edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], rx_i};
      prev_q <= sync_q[SYNC_FF-1];
    end
  end

  assign rx_s_o     = sync_q[SYNC_FF-1];
  assign rx_ahead_o = sync_q[SYNC_FF-2];
  assign rx_prev_o  = prev_q;
  assign fall_o     = prev_q & ~sync_q[SYNC_FF-1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: recovers LSB-first bytes, pulses o_valid (good stop) or o_frame_err (low stop).
// Latency: o_valid rises SYNC_FF+1 clocks after mid-stop-bit on the pin. Optional macro: UART_RX_MAJORITY_EN.
// Backpressure: none; pulses are single-cycle and o_data holds until the next good byte.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CPB     = CPB_DEFAULT,
  parameter int SYNC_FF = 2
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_8n1_if.slave  bus
);

  localparam logic [CNT_W-1:0] HALF_CNT      = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(CPB - 1);
  localparam logic [3:0]       START_BIT     = 4'(START_IDX);
  localparam logic [3:0]       FIRST_DATA    = 4'(START_IDX + 1);
  localparam logic [3:0]       LAST_DATA_IDX = 4'(DATA_BITS);
  localparam logic [3:0]       STOP_BIT      = 4'(STOP_IDX);

  logic rx_s;
  logic rx_ahead;
  logic rx_prev;
  logic fall;
  logic sample;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  uart_rx_sync #(.SYNC_FF(SYNC_FF)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (bus.i_Rx),
    .rx_s_o     (rx_s),
    .rx_ahead_o (rx_ahead),
    .rx_prev_o  (rx_prev),
    .fall_o     (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // The vote over counts P-1, P, P+1 is formed at count P: the P+1 value is
  // already sitting one stage up the synchronizer, so sample timing is unchanged.
  assign sample = maj3(rx_prev, rx_s, rx_ahead);
`else
  logic unused_taps;
  assign sample      = rx_s;
  assign unused_taps = rx_ahead ^ rx_prev;
`endif

  // state, counters, shift register and output pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= START_BIT;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // next-state: bit timing, sampling and frame decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = START_BIT;
        if (fall) state_d = START;
      end

      // confirm the start bit at its middle; a high line here was a glitch
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!sample) begin
            state_d = DATA;
            bit_d   = FIRST_DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // counting from mid-start, CPB-1 lands on the middle of each data bit
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA_IDX) begin
            state_d = STOP;
            bit_d   = STOP_BIT;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // leave at mid-stop so a back-to-back start edge is not missed
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (sample) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
            bit_d   = START_BIT;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // break / framing recovery: one error per low period, resume once idle-high
      WAIT_HI: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
          bit_d   = START_BIT;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = START_BIT;
      end
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_bit_count = bit_q;
  assign bus.o_CPB_count = cnt_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 at 16 clocks per bit: directed vectors, corner sequences, random frames.
// Latency: frames are driven bit-serially, results checked after the line idles.
// Backpressure: none; the monitor captures every o_valid / o_frame_err pulse.
module tb_uart_rx_8n1;

  localparam int BIT_CLK = 16;
  localparam int FRAME   = 10 * BIT_CLK;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  uart_rx_8n1_if u_if ();

  uart_rx_8n1 #(.CPB(BIT_CLK), .SYNC_FF(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: capture pulses at the falling edge
  logic [7:0] got_q[$];
  int valid_cnt, ferr_cnt, excl_viol, last_valid_cyc;
  logic busy_prev, pulse_prev, busy_at_valid, busy_before_valid;

  initial begin
    valid_cnt = 0; ferr_cnt = 0; excl_viol = 0; last_valid_cyc = 0;
    busy_prev = 1'b0; pulse_prev = 1'b0; busy_at_valid = 1'b1; busy_before_valid = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.o_valid) begin
        got_q.push_back(u_if.o_data);
        valid_cnt++;
        last_valid_cyc    = cyc;
        busy_at_valid     = u_if.o_busy;
        busy_before_valid = busy_prev;
      end
      if (u_if.o_frame_err) ferr_cnt++;
      if (u_if.o_valid && u_if.o_frame_err) excl_viol++;
      if ((u_if.o_valid || u_if.o_frame_err) && pulse_prev) excl_viol++;
      pulse_prev = u_if.o_valid | u_if.o_frame_err;
      busy_prev  = u_if.o_busy;
    end else begin
      pulse_prev = 1'b0;
      busy_prev  = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      u_if.i_Rx = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      u_if.i_Rx = 1'b0;
    end
  endtask

  // one 8N1 frame; glitch_bit>=0 inverts one clock at the middle of that data bit;
  // ncyc < FRAME truncates the frame
  int t_start;
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit, input int ncyc);
    logic [9:0] bits;
    int n;
    bits = {stop, d, 1'b0};
    n = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        if (n < ncyc) begin
          @(posedge clk); #1;
          if (n == 0) t_start = cyc;
          u_if.i_Rx = bits[b] ^ logic'(glitch_bit >= 0 && b == glitch_bit + 1 && c == BIT_CLK / 2);
          n++;
        end
      end
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop;
    int         low_after;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] exp_q[$];

  initial begin
    int v0, f0, base, nf;
    logic [7:0] b2b[3];
    logic [7:0] d;
    logic good;
    logic [7:0] glitch_exp;

    checks = 0; failures = 0; cyc = 0;

    vecs[0] = '{8'hA5, 1'b1,  0, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 40, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1,  0, 1, 0, 8'h81};
    vecs[3] = '{8'h0F, 1'b1,  0, 1, 0, 8'h0F};
    vecs[4] = '{8'hF0, 1'b0,  0, 0, 1, 8'h0F};
    vecs[5] = '{8'h7E, 1'b1,  0, 1, 0, 8'h7E};

    // reset state
    rst = 1'b1;
    u_if.i_Rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(u_if.o_data), 32'h00);
    check("rst_valid", 32'(u_if.o_valid), 32'h0);
    check("rst_ferr",  32'(u_if.o_frame_err), 32'h0);
    check("rst_busy",  32'(u_if.o_busy), 32'h0);
    check("rst_bitcnt", 32'(u_if.o_bit_count), 32'h0);
    check("rst_cpbcnt", 32'(u_if.o_CPB_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    // single A5 frame: latency and busy/valid alignment
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, -1, FRAME);
    idle(24);
    check("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("a5_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
    check("a5_data", 32'(u_if.o_data), 32'hA5);
    // mid-stop on the pin is 9.5 bits in; +SYNC_FF+1 clocks of pipeline
    check("a5_latency", 32'(last_valid_cyc - t_start), 32'(9 * BIT_CLK + BIT_CLK / 2 + 3));
    check("a5_busy_at_valid", 32'(busy_at_valid), 32'h0);
    check("a5_busy_before_valid", 32'(busy_before_valid), 32'h1);

    // directed vectors, including framing errors with and without a held-low break
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(vecs[i].din, vecs[i].stop, -1, FRAME);
      hold_low(vecs[i].low_after);
      idle(24);
      check($sformatf("vec%0d_valid_cnt", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_ferr_cnt", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_f));
      check($sformatf("vec%0d_data", i), 32'(u_if.o_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy", i), 32'(u_if.o_busy), 32'h0);
    end

    // back-to-back frames with no idle gap
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
    base = got_q.size();
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1, -1, FRAME);
    idle(24);
    check("b2b_count", 32'(got_q.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      if (base + i < got_q.size())
        check($sformatf("b2b_data%0d", i), 32'(got_q[base + i]), 32'(b2b[i]));

    // 4-clock start glitch
    idle(20);
    v0 = valid_cnt; f0 = ferr_cnt;
    hold_low(4);
    idle(2);
    check("glitch_busy_seen", 32'(u_if.o_busy), 32'h1);
    idle(40);
    check("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("glitch_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_busy_after", 32'(u_if.o_busy), 32'h0);
    check("glitch_bitcnt", 32'(u_if.o_bit_count), 32'h0);

    // one-clock inversion at the middle of data bit 2 of C3
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hC3;
`else
    glitch_exp = 8'hC7;
`endif
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b1, 2, FRAME);
    idle(24);
    check("bitglitch_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("bitglitch_data", 32'(u_if.o_data), 32'(glitch_exp));

    // reset in the middle of data bit 4
    idle(10);
    send_frame(8'h7E, 1'b1, -1, 5 * BIT_CLK + BIT_CLK / 2 + 1);
    check("midframe_bitcnt", 32'(u_if.o_bit_count), 32'd5);
    check("midframe_busy", 32'(u_if.o_busy), 32'h1);
    rst = 1'b1;
    #1;
    check("arst_data",  32'(u_if.o_data), 32'h00);
    check("arst_valid", 32'(u_if.o_valid), 32'h0);
    check("arst_ferr",  32'(u_if.o_frame_err), 32'h0);
    check("arst_busy",  32'(u_if.o_busy), 32'h0);
    check("arst_bitcnt", 32'(u_if.o_bit_count), 32'h0);
    check("arst_cpbcnt", 32'(u_if.o_CPB_count), 32'h0);
    u_if.i_Rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h7E, 1'b1, -1, FRAME);
    idle(24);
    check("post_rst_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("post_rst_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
    check("post_rst_data", 32'(u_if.o_data), 32'h7E);

    // random frames against a reference model: good stop -> byte delivered, low stop -> one error
    exp_q.delete();
    base = got_q.size();
    f0 = ferr_cnt;
    nf = 0;
    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(d, good, -1, FRAME);
      if (good) begin
        exp_q.push_back(d);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
      end else begin
        nf++;
        hold_low($urandom_range(0, 30));
        idle(BIT_CLK + $urandom_range(0, 3));
      end
    end
    idle(30);
    check("rand_count", 32'(got_q.size() - base), 32'(exp_q.size()));
    check("rand_ferr_cnt", 32'(ferr_cnt - f0), 32'(nf));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        check($sformatf("rand_data%0d", i), 32'(got_q[base + i]), 32'(exp_q[i]));

    // pulses never overlap and never repeat on consecutive cycles
    check("pulse_exclusive", 32'(excl_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
